fetch_unit: RTL and testbench

//   Instruction fetch stage; sits directly upstream of decode and immediate generation.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: the decode-side fetch entry and the canonical NOP.
// Imported by the fetch stage and its buffers.
package riscv_pkg;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Instruction fetches are always word aligned; the low two address bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Registered synchronous FIFO with flush and occupancy count; head entry is visible
// combinationally on pop_data whenever count is non-zero.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign do_pop   = pop && !empty;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // always_ff block sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the pointers and count define which slots
    // are meaningful, so clearing the data would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word requests to instruction
// memory, pairs in-order responses with their PCs and hands {instr, pc} to decode.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);
    localparam int          CW           = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] pcq_count;
    logic [CW-1:0] fifo_count;
    logic [31:0]   pcq_head;
    fetch_entry_t  fifo_in;
    fetch_entry_t  fifo_head;
    logic          has_credit;
    logic          req_fire;
    logic          rsp_fire;
    logic          rsp_keep;
    logic          id_fire;

    // Every slot the entry FIFO could ever need is reserved at request time, so a
    // response always has room and memory never has to be back-pressured.
    assign has_credit     = ({1'b0, outstanding} + {1'b0, fifo_count}) < CREDIT_LIMIT;
    assign imem_req_valid = !rst && has_credit;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses during a redirect cycle or while stale requests remain are discarded.
    assign rsp_fire = imem_rsp_valid && !rst;
    assign rsp_keep = rsp_fire && !redirect_valid && (drop_cnt == '0);
    assign fifo_in  = '{instr: imem_rsp_data, pc: pcq_head};

    assign id_valid = !rst && (fifo_count != '0);
    assign id_instr = id_valid ? fifo_head.instr : INSTR_NOP;
    assign id_pc    = id_valid ? fifo_head.pc : 32'h0000_0000;
    assign id_fire  = id_valid && id_ready;

    // NOTE: every variable written in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        outstanding_next = outstanding;
        if (req_fire && !rsp_fire) begin
            outstanding_next = outstanding + 1'b1;
        end else if (!req_fire && rsp_fire) begin
            outstanding_next = outstanding - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                pc       <= word_align(redirect_pc);
                drop_cnt <= outstanding_next;
            end else begin
                if (req_fire) pc <= pc + 32'd4;
                if (rsp_fire && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH(32),
        .DEPTH(FIFO_DEPTH)
    ) u_pc_queue (
        .clk      (clk),
        .rst      (rst),
        .flush    (1'b0),
        .push     (req_fire),
        .push_data(pc),
        .pop      (rsp_fire),
        .pop_data (pcq_head),
        .count    (pcq_count)
    );

    sync_fifo #(
        .WIDTH($bits(fetch_entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_entry_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (rsp_keep),
        .push_data(fifo_in),
        .pop      (id_fire),
        .pop_data (fifo_head),
        .count    (fifo_count)
    );

    a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outstanding != '0))
        else $error("fetch_unit: instruction response with no outstanding request");

    a_pcq_tracks_outstanding: assert property (@(posedge clk) disable iff (rst)
        pcq_count == outstanding)
        else $error("fetch_unit: PC queue occupancy differs from outstanding count");

    a_drop_bounded: assert property (@(posedge clk) disable iff (rst)
        drop_cnt <= outstanding)
        else $error("fetch_unit: more responses to drop than requests in flight");

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an in-order latency-configurable memory model answers
// accepted requests, and a scoreboard of expected decode PCs is checked on every handshake.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instr      (id_instr),
        .id_pc         (id_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t    mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] req_log[$];
    int          cyc     = 0;
    int          mem_lat = 1;
    int          errors  = 0;
    int          checks  = 0;
    logic        saw_rsp = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive the memory response, sample handshakes, advance the model.
    task automatic tick();
        logic        req_fire;
        logic        rsp_fire;
        logic        id_fire;
        logic [31:0] req_addr;
        logic [31:0] exp_pc;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_q[0].addr ^ DATA_KEY;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
        req_fire = imem_req_valid && imem_req_ready;
        req_addr = imem_req_addr;
        rsp_fire = imem_rsp_valid;
        id_fire  = id_valid && id_ready;
        saw_rsp  = rsp_fire;
        if (id_fire) begin
            check("id_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_pc = exp_q.pop_front();
                check("id_pc", id_pc, exp_pc);
                check("id_instr", id_instr, exp_pc ^ DATA_KEY);
            end
        end
        @(posedge clk);
        if (rst) begin
            mem_q.delete();
        end else begin
            if (rsp_fire) void'(mem_q.pop_front());
            if (req_fire) begin
                mem_q.push_back('{addr: req_addr, due: cyc + mem_lat});
                req_log.push_back(req_addr);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        check("rst_gates_req_valid", imem_req_valid, 0);
        check("rst_gates_id_valid", id_valid, 0);
        tick();
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_id_valid", id_valid, 0);
        check("rst_id_instr", id_instr, INSTR_NOP);
        check("rst_id_pc", id_pc, 0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        req_log.delete();
    endtask

    // Accept decode entries until every expected one has arrived, then let the buffer refill.
    task automatic drain(input string tag);
        int budget = 200;
        while (exp_q.size() != 0 && budget > 0) begin
            id_ready = 1'b1;
            tick();
            budget--;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
        id_ready = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;

        // Sequential stream, latency 1, decode always ready.
        do_reset();
        mem_lat  = 1;
        id_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
        tick();
        tick();
        check("t1_fill_valid", id_valid, 1);
        check("t1_fill_pc", id_pc, 32'h0);
        drain("t1");
        for (int i = 0; i < 8; i++) check("t1_req_addr", req_log[i], 32'(4 * i));

        // Decode stalled: credit stops requests after two.
        do_reset();
        mem_lat  = 1;
        id_ready = 1'b0;
        repeat (6) tick();
        check("t2_req_count", req_log.size(), 2);
        check("t2_req0", req_log[0], 32'h0);
        check("t2_req1", req_log[1], 32'h4);
        check("t2_req_stalled", imem_req_valid, 0);
        check("t2_id_valid", id_valid, 1);
        check("t2_id_head", id_pc, 32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        drain("t2");
        check("t2_req2", req_log[2], 32'h8);

        // Redirect with two requests in flight: both late responses are dropped.
        do_reset();
        mem_lat  = 3;
        id_ready = 1'b1;
        tick();
        tick();
        check("t3_credit_stall", imem_req_valid, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        check("t3_new_pc", imem_req_addr, 32'h100);
        check("t3_no_id", id_valid, 0);
        repeat (4) begin
            tick();
            check("t3_no_id", id_valid, 0);
        end
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        drain("t3");
        check("t3_req_after_redirect", req_log[2], 32'h100);

        // Redirect in the same cycle as a response and a decode handshake.
        do_reset();
        mem_lat  = 1;
        id_ready = 1'b1;
        exp_q.push_back(32'h0);
        tick();
        tick();
        check("t4_pre_valid", id_valid, 1);
        check("t4_pre_pc", id_pc, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        check("t4_rsp_same_cycle", saw_rsp, 1);
        check("t4_head_consumed", exp_q.size(), 0);
        check("t4_flushed", id_valid, 0);
        check("t4_new_pc", imem_req_addr, 32'h200);
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        drain("t4");

        // Misaligned redirect target, then a back-to-back redirect that wraps the PC.
        do_reset();
        mem_lat        = 1;
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        check("t5_align", imem_req_addr, 32'h100);
        check("t5_credit", imem_req_valid, 1);
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("t5_latest_wins", imem_req_addr, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        drain("t5");
        check("t5_req_top", req_log[2], 32'hFFFF_FFFC);
        check("t5_req_wrap", req_log[3], 32'h0);

        // Reset mid-stream with two requests in flight and stale drops pending.
        do_reset();
        mem_lat  = 3;
        id_ready = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        tick();
        redirect_valid = 1'b0;
        check("t6_in_flight_stall", imem_req_valid, 0);
        check("t6_redirect_pc", imem_req_addr, 32'h300);
        do_reset();
        mem_lat = 1;
        check("t6_restart_addr", imem_req_addr, 32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        drain("t6");
        check("t6_first_req", req_log[0], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
